serial_add: RTL and testbench
=============================

Name: serial_add

Overview:
- Parametrised, multi-cycle ripple adder/subtractor built from the team's full-adder cell, replicated DIGIT times.
- Processes a WIDTH-bit operand pair DIGIT bits per clock.
- Registers the carry between slices, giving a small-area adder for datapaths that can tolerate latency.
- Uses a valid/ready handshake on input and output; sits between operand registers and the accumulator/ALU result path.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of DIGIT, WIDTH >= DIGIT >= 1.
- DIGIT, 4, bits added per clock, i.e. the number of full-adder cells instantiated.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- inValid  input  1  operands and op are valid this cycle.
- inReady  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- carryIN  input  1  carry-in, add mode only.
- op  input  1  0 = add (a+b+carryIN); 1 = subtract (a-b, computed as a+~b+1; carryIN ignored).
- outValid  output  1  sum/carryOUT/overflow valid.
- outReady  input  1  consumer accepts the result.
- sum  output  WIDTH  result, low WIDTH bits.
- carryOUT  output  1  carry out of the MSB. In sub mode, 1 means no borrow (a >= b unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, inReady=1, outValid=0;
  - sum=0, carryOUT=0, overflow=0;
  - slice counter=0, internal carry=0.
  - Reset mid-operation aborts it; no result is produced.
- States:
  - IDLE: inReady=1, outValid=0. On inValid=1, capture:
    - a;
    - b, or ~b when op=1;
    - initial carry = carryIN (op=0) or 1 (op=1).
    - Then clear the counter and go to RUN.
  - RUN: inReady=0.
    - Each cycle, add slice k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) of the captured operands with the registered carry through DIGIT chained full adders.
    - Write the slice result into sum bits of slice k, register the slice carry-out, and increment k.
    - On the last slice (k = WIDTH/DIGIT-1):
      - carryOUT = final carry;
      - overflow = carry into MSB XOR carry out of MSB;
      - go to DONE.
  - DONE: outValid=1, inReady=0. Outputs are held stable until outReady=1. On outValid&&outReady, go to IDLE next cycle.
- Latency:
  - Acceptance edge to outValid high is WIDTH/DIGIT+1 edges (capture edge plus one RUN edge per slice).
  - Example: WIDTH=16, DIGIT=4 gives outValid in the 5th cycle after acceptance.
  - Throughput is one operation per WIDTH/DIGIT+2 cycles; no back-to-back acceptance in DONE.
- Output visibility:
  - sum, carryOUT and overflow retain their last values in IDLE after handshake.
  - While in RUN, sum updates per slice and is not valid.
- Input handling:
  - Operands are sampled only on the accepting edge (IDLE && inValid). Changes to a/b/op/carryIN afterwards have no effect.
  - inValid while inReady=0 is ignored; the source must hold it.
- Degenerate case DIGIT=WIDTH: a single RUN cycle, latency 2.
- All arithmetic is modulo 2^WIDTH; carryOUT is the (WIDTH+1)th bit.

Test Plan:
- Reset mid-RUN:
  - Stimulus: WIDTH=16, DIGIT=4; a=0x1234, b=0x0FFF, carryIN=1, op=0; assert rst during the 2nd RUN cycle, release, then resubmit.
  - Required: outValid=0 and sum=0 immediately on rst assertion; after resubmission, sum=0x2234, carryOUT=0, overflow=0, outValid on the 5th cycle after acceptance.
- Full ripple across all slices: a=0xFFFF, b=0x0001, carryIN=0, op=0 -> sum=0x0000, carryOUT=1, overflow=0.
- Signed overflow:
  - add: a=0x7FFF, b=0x0001, op=0 -> sum=0x8000, overflow=1, carryOUT=0.
  - sub: a=0x8000, b=0x0001, op=1 -> sum=0x7FFF, overflow=1, carryOUT=1.
- Subtract with borrow: a=0x0003, b=0x0005, op=1, carryIN=1 -> sum=0xFFFE, carryOUT=0, overflow=0 (carryIN ignored).
- Output backpressure and input hold:
  - Stimulus: hold outReady=0 for 10 cycles after outValid; keep inValid=1 with new operands throughout.
  - Required: outValid and result stable; inReady=0; new operands not accepted until the cycle after the outValid&&outReady handshake.
- Parameter sweep:
  - Configurations: DIGIT=1, WIDTH=8 and DIGIT=8, WIDTH=8, with 1000 random operand/op sets.
  - Required: results match the reference model; latency is 9 and 2 cycles respectively.

Source files
------------

// File: rtl/serial_add.sv
// serial_add: multi-cycle ripple adder/subtractor.
// A WIDTH-bit operand pair is added DIGIT bits per clock through a chain of
// DIGIT full-adder cells; the carry between slices is held in a register.
// Subtraction is a + ~b + 1: b is inverted and the carry preset at capture.
// Input and output use a valid/ready handshake; all outputs are registered.

// Single-bit full-adder cell, replicated DIGIT times by serial_add.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_add #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIN,
  input  logic             op,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             carryOUT,
  output logic             overflow
);

  // Number of slices processed per operation and the widths needed to
  // count them and to address a bit inside the operand.
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Registered state
  state_t            state_q,     state_d;
  logic [WIDTH-1:0]  a_q,         a_d;
  logic [WIDTH-1:0]  b_q,         b_d;       // holds ~b in subtract mode
  logic              carry_q,     carry_d;   // carry into the current slice
  logic [CW-1:0]     cnt_q,       cnt_d;     // current slice index
  logic [WIDTH-1:0]  sum_q,       sum_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q,  overflow_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;

  // Slice datapath
  logic [IW-1:0]     slice_base_s;
  logic [DIGIT-1:0]  a_slice_s;
  logic [DIGIT-1:0]  b_slice_s;
  logic [DIGIT-1:0]  slice_sum_s;
  logic [DIGIT:0]    chain_s;                // chain_s[i] = carry into bit i
  logic              last_slice_s;

  // LSB index of the slice being worked on. When DIGIT == WIDTH the count
  // is always zero, so truncating DIGIT to IW bits cannot change the result.
  assign slice_base_s = IW'(cnt_q) * IW'(DIGIT);
  assign a_slice_s    = a_q[slice_base_s +: DIGIT];
  assign b_slice_s    = b_q[slice_base_s +: DIGIT];
  assign last_slice_s = (cnt_q == LAST_SLICE);
  assign chain_s[0]   = carry_q;

  // Ripple chain of DIGIT full-adder cells for one slice.
  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    full_adder u_fa (
      .a  (a_slice_s[g]),
      .b  (b_slice_s[g]),
      .ci (chain_s[g]),
      .s  (slice_sum_s[g]),
      .co (chain_s[g+1])
    );
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (inValid) begin
          a_d         = a;
          b_d         = op ? ~b : b;
          carry_d     = op ? 1'b1 : carryIN;
          cnt_d       = {CW{1'b0}};
          in_ready_d  = 1'b0;
          out_valid_d = 1'b0;
          state_d     = RUN;
        end else begin
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end

      RUN: begin
        sum_d[slice_base_s +: DIGIT] = slice_sum_s;
        carry_d                      = chain_s[DIGIT];
        if (last_slice_s) begin
          // Overflow compares the carries into and out of the operand MSB,
          // which are the top two taps of the last slice's chain.
          carry_out_d = chain_s[DIGIT];
          overflow_d  = chain_s[DIGIT] ^ chain_s[DIGIT-1];
          cnt_d       = {CW{1'b0}};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d       = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign inReady  = in_ready_q;
  assign outValid = out_valid_q;
  assign sum      = sum_q;
  assign carryOUT = carry_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: a 16/4 instance for the functional cases and
// 8/1 and 8/8 instances driven in parallel for the configuration sweep.
module tb_serial_add;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // 16/4 instance signals
  logic        iv16 = 1'b0, or16 = 1'b1, ci16 = 1'b0, op16 = 1'b0;
  logic [15:0] a16 = 16'h0, b16 = 16'h0;
  logic        ir16, ov16, co16, of16;
  logic [15:0] s16;

  // 8-bit instances share their inputs
  logic        iv8 = 1'b0, or8 = 1'b1, ci8 = 1'b0, op8 = 1'b0;
  logic [7:0]  a8 = 8'h0, b8 = 8'h0;
  logic        ir_d1, ov_d1, co_d1, of_d1;
  logic        ir_d8, ov_d8, co_d8, of_d8;
  logic [7:0]  s_d1, s_d8;

  serial_add #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .inValid(iv16), .inReady(ir16), .a(a16), .b(b16),
    .carryIN(ci16), .op(op16), .outValid(ov16), .outReady(or16),
    .sum(s16), .carryOUT(co16), .overflow(of16)
  );

  serial_add #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .rst(rst), .inValid(iv8), .inReady(ir_d1), .a(a8), .b(b8),
    .carryIN(ci8), .op(op8), .outValid(ov_d1), .outReady(or8),
    .sum(s_d1), .carryOUT(co_d1), .overflow(of_d1)
  );

  serial_add #(.WIDTH(8), .DIGIT(8)) u_dut_d8 (
    .clk(clk), .rst(rst), .inValid(iv8), .inReady(ir_d8), .a(a8), .b(b8),
    .carryIN(ci8), .op(op8), .outValid(ov_d8), .outReady(or8),
    .sum(s_d8), .carryOUT(co_d8), .overflow(of_d8)
  );

  // Count one comparison and report it if it does not match.
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // With iv16 already raised, step edges until outValid; lat counts edges
  // from the accepting edge (edge 1), or stays 0 if the budget runs out.
  task automatic wait16(output int lat);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) iv16 = 1'b0;
      if (ov16) lat = n;
    end
  endtask

  // One complete 16-bit operation with immediate output acceptance.
  task automatic op16_run(input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic civ,
                          input logic opv, input logic [15:0] es,
                          input logic eco, input logic eof);
    int lat;
    a16 = av; b16 = bv; ci16 = civ; op16 = opv; or16 = 1'b1; iv16 = 1'b1;
    wait16(lat);
    check_val({tag, "_lat"}, lat, 5);
    check_val({tag, "_sum"}, s16, es);
    check_val({tag, "_cout"}, co16, eco);
    check_val({tag, "_ovf"}, of16, eof);
    @(posedge clk); #1;
    check_val({tag, "_ready_after"}, ir16, 1'b1);
    check_val({tag, "_valid_after"}, ov16, 1'b0);
  endtask

  initial begin
    int lat;
    int lat1, lat8;
    logic [7:0] ra, rb, rbx;
    logic       rop, rci, ecin;
    logic [8:0] full;
    logic       eovf;

    // Reset state
    #12;
    check_val("rst_ready", ir16, 1'b1);
    check_val("rst_valid", ov16, 1'b0);
    check_val("rst_sum", s16, 16'h0);
    check_val("rst_cout", co16, 1'b0);
    check_val("rst_ovf", of16, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset during the second RUN cycle, then resubmit
    a16 = 16'h1234; b16 = 16'h0FFF; ci16 = 1'b1; op16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;                      // accept
    iv16 = 1'b0;
    @(posedge clk); #1;                      // slice 0 done, 2nd RUN cycle
    check_val("midrun_sum_partial", s16, 16'h0004);
    rst = 1'b1; #1;
    check_val("midrun_rst_valid", ov16, 1'b0);
    check_val("midrun_rst_sum", s16, 16'h0);
    check_val("midrun_rst_ready", ir16, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op16_run("resubmit", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);

    // Directed arithmetic cases
    op16_run("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16_run("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16_run("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op16_run("sub_brw",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op16_run("add_cin",  16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure with inValid held and operands changing after acceptance
    a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; op16 = 1'b0;
    or16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;                      // accept first operation
    a16 = 16'h0101; b16 = 16'h0202; op16 = 1'b1; ci16 = 1'b1;
    lat = 0;
    for (int n = 2; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (ov16) lat = n;
    end
    check_val("bp_lat", lat, 5);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check_val("bp_valid_hold", ov16, 1'b1);
      check_val("bp_sum_hold", s16, 16'h3333);
      check_val("bp_ready_low", ir16, 1'b0);
    end
    or16 = 1'b1;
    @(posedge clk); #1;                      // handshake edge
    check_val("bp_hs_valid", ov16, 1'b0);
    check_val("bp_hs_ready", ir16, 1'b1);
    check_val("bp_hs_sum_kept", s16, 16'h3333);
    // iv16 is still high: the held subtract 0x0101 - 0x0202 goes in now
    wait16(lat);
    check_val("bp_next_lat", lat, 5);
    check_val("bp_next_sum", s16, 16'hFEFF);
    check_val("bp_next_cout", co16, 1'b0);
    check_val("bp_next_ovf", of16, 1'b0);
    @(posedge clk); #1;

    // Sweep of the 8/1 and 8/8 configurations against a reference sum
    for (int t = 0; t < 1000; t++) begin
      ra  = 8'($urandom_range(255));
      rb  = 8'($urandom_range(255));
      rop = 1'($urandom_range(1));
      rci = 1'($urandom_range(1));
      rbx  = rop ? ~rb : rb;
      ecin = rop ? 1'b1 : rci;
      full = {1'b0, ra} + {1'b0, rbx} + {8'h00, ecin};
      eovf = (ra[7] == rbx[7]) && (full[7] != ra[7]);
      a8 = ra; b8 = rb; op8 = rop; ci8 = rci; or8 = 1'b1; iv8 = 1'b1;
      lat1 = 0; lat8 = 0;
      for (int n = 1; n <= 20 && (lat1 == 0 || lat8 == 0); n++) begin
        @(posedge clk); #1;
        if (n == 1) iv8 = 1'b0;
        if (ov_d1 && lat1 == 0) begin
          lat1 = n;
          check_val("d1_sum", s_d1, full[7:0]);
          check_val("d1_cout", co_d1, full[8]);
          check_val("d1_ovf", of_d1, eovf);
        end
        if (ov_d8 && lat8 == 0) begin
          lat8 = n;
          check_val("d8_sum", s_d8, full[7:0]);
          check_val("d8_cout", co_d8, full[8]);
          check_val("d8_ovf", of_d8, eovf);
        end
      end
      check_val("d1_lat", lat1, 9);
      check_val("d8_lat", lat8, 2);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
